stopwatch_display_driver: RTL and testbench

Consumes the four BCD digits produced by the stopwatch counter (min_tens, min_ones, sec_tens, sec_ones) and drives a 4-digit, common-anode, time-multiplexed seven-segment display. The selected digit blinks while adjust mode is active. Sits between the counter and the board pins, clocked by the same clk_c. Digits are snapshotted once per scan frame, so a frame never shows a mix of old and new values.

---
 rtl/stopwatch_pkg.sv | 47 ++++
 rtl/stopwatch_display_driver_bcd_to_seg7.sv | 33 +++
 rtl/stopwatch_display_driver.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_display_driver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Constants shared by the stopwatch counter and its display driver:
//   - adjust-digit select encodings (SEL input)
//   - display slot indices (slot n drives an[n])
//   - active-low seven-segment patterns, ordered {g,f,e,d,c,b,a}
//   - the blink phase type used in adjust mode
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  localparam int NUM_DIGITS = 4;

  // Adjust-digit select encodings.
  localparam logic [1:0] SEL_SEC_ONES = 2'b00;
  localparam logic [1:0] SEL_SEC_TENS = 2'b01;
  localparam logic [1:0] SEL_MIN_ONES = 2'b10;
  localparam logic [1:0] SEL_MIN_TENS = 2'b11;

  // Display slots use the same numbering as SEL, so blanking compares them directly.
  localparam logic [1:0] SLOT_SEC_ONES = SEL_SEC_ONES;
  localparam logic [1:0] SLOT_SEC_TENS = SEL_SEC_TENS;
  localparam logic [1:0] SLOT_MIN_ONES = SEL_MIN_ONES;
  localparam logic [1:0] SLOT_MIN_TENS = SEL_MIN_TENS;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // All anodes disabled (active-low).
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/stopwatch_display_driver_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to active-low seven-segment decoder.
// Non-decimal codes (10..15) render as a dash so a corrupt counter value is
// visible on the display rather than silently showing a plausible digit.
// Ports:
//   bcd_i  in  4  BCD digit
//   seg_o  out 7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_driver.sv
// -----------------------------------------------------------------------------
// stopwatch_display_driver
// Drives a 4-digit common-anode multiplexed seven-segment display from the
// stopwatch counter's BCD digits. Digits are snapshotted once per scan frame so
// a frame never mixes old and new values. In adjust mode the selected digit
// blinks (segments off, anode still enabled) with a BLINK_DIV half-period.
// Parameters:
//   REFRESH_DIV  clk_c cycles per digit slot (>= 2)
//   BLINK_DIV    clk_c cycles per blink half-period (>= 1)
// Ports:
//   clk_c     in   1  system clock
//   reset_c   in   1  asynchronous active-high reset
//   min_tens  in   4  BCD minutes tens
//   min_ones  in   4  BCD minutes ones
//   sec_tens  in   4  BCD seconds tens
//   sec_ones  in   4  BCD seconds ones
//   ADJ       in   1  adjust-mode switch (asynchronous)
//   SEL       in   2  adjust digit select (asynchronous)
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp        out  1  decimal point, active-low, registered
//   an        out  4  anode enables, active-low one-hot, registered
// -----------------------------------------------------------------------------
module stopwatch_display_driver
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       ADJ,
  input  logic [1:0] SEL,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

  // Two-flop synchronizers for the switch inputs.
  logic       adj_meta_q, adj_sync_q;
  logic [1:0] sel_meta_q, sel_sync_q;

  logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e  phase_q, phase_d;

  // snap_q[n] holds the digit shown in slot n.
  logic [3:0] snap_q [NUM_DIGITS];

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;

  logic       frame_start;
  logic       blanked;
  logic [3:0] slot_digit;
  logic [6:0] digit_seg;

  assign frame_start = (refresh_cnt_q == '0) && (slot_q == SLOT_SEC_ONES);
  assign slot_digit  = snap_q[slot_q];

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd_i (slot_digit),
    .seg_o (digit_seg)
  );

  // Scan timing and blink phase.
  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    refresh_cnt_d = refresh_cnt_q + 1'b1;
    slot_d        = slot_q;
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      slot_d        = slot_q + 2'd1;
    end

    // Leaving adjust mode parks the blink at the start of a visible half, so
    // the next entry always begins with a full visible half-period.
    blink_cnt_d = '0;
    phase_d     = PHASE_VISIBLE;
    if (adj_sync_q) begin
      phase_d = phase_q;
      if (blink_cnt_q == BLINK_LAST) begin
        phase_d = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Output pattern for the current slot position.
  always_comb begin
    blanked = adj_sync_q && (phase_q == PHASE_HIDDEN) && (sel_sync_q == slot_q);
    an_d    = AN_OFF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    // The first cycle of every slot is dark so the previous digit's segments
    // never ghost onto the next anode while both are switching.
    if (refresh_cnt_q != '0) begin
      an_d = ~(4'b0001 << slot_q);
      if (!blanked) begin
        seg_d = digit_seg;
        dp_d  = (slot_q != SLOT_MIN_ONES);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk_c or posedge reset_c) begin
    if (reset_c) begin
      adj_meta_q    <= 1'b0;
      adj_sync_q    <= 1'b0;
      sel_meta_q    <= 2'b00;
      sel_sync_q    <= 2'b00;
      refresh_cnt_q <= '0;
      slot_q        <= 2'd0;
      blink_cnt_q   <= '0;
      phase_q       <= PHASE_VISIBLE;
      // NOTE: the snapshot array is only four nibbles of flops, and resetting
      // it keeps the display deterministic before the first snapshot.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap_q[i] <= 4'd0;
      end
      an_q          <= AN_OFF;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
    end else begin
      adj_meta_q    <= ADJ;
      adj_sync_q    <= adj_meta_q;
      sel_meta_q    <= SEL;
      sel_sync_q    <= sel_meta_q;
      refresh_cnt_q <= refresh_cnt_d;
      slot_q        <= slot_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      if (frame_start) begin
        snap_q[SLOT_SEC_ONES] <= sec_ones;
        snap_q[SLOT_SEC_TENS] <= sec_tens;
        snap_q[SLOT_MIN_ONES] <= min_ones;
        snap_q[SLOT_MIN_TENS] <= min_tens;
      end
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_display_driver
// Scoreboard bench for stopwatch_display_driver with REFRESH_DIV=4, BLINK_DIV=8.
// The stimulus process pushes the expected {an,seg,dp} for each future sample
// (tagged with the negedge index at which it must appear); the monitor samples
// the outputs on every falling edge and pops/compares matching entries.
// Edge numbering: edge e is the e-th rising edge after reset release; the
// outputs registered at edge e reflect scan position c=e-1 (refresh=c%4,
// slot=(c/4)%4), so frame k occupies edges 16k+1..16k+16.
// -----------------------------------------------------------------------------
module tb_stopwatch_display_driver;

  logic       clk_c = 1'b0;
  logic       reset_c = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       ADJ;
  logic [1:0] SEL;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  stopwatch_display_driver #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (8)
  ) dut (
    .clk_c    (clk_c),
    .reset_c  (reset_c),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .ADJ      (ADJ),
    .SEL      (SEL),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  always #5 clk_c = ~clk_c;

  // Hand-written active-low patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;
  localparam logic [6:0] S4    = 7'b0011001;
  localparam logic [6:0] S5    = 7'b0010010;
  localparam logic [6:0] S7    = 7'b1111000;
  localparam logic [6:0] S9    = 7'b0010000;
  localparam logic [6:0] SDASH = 7'b0111111;
  localparam logic [6:0] SOFF  = 7'b1111111;

  typedef struct {
    int         at;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   neg_cnt  = 0;   // written only by the monitor
  int   e_now    = 0;   // rising edges since the last reset release
  int   rel_base = 0;   // negedge index for edge 0 of the current run

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (an/seg/dp packed)", name, act, exp);
    end
  endtask

  // Monitor: sample away from the rising edge and compare due entries.
  always @(negedge clk_c) begin
    exp_t it;
    neg_cnt = neg_cnt + 1;
    while (sb.size() > 0 && sb[0].at <= neg_cnt) begin
      it = sb.pop_front();
      if (it.at < neg_cnt) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: sample slot %0d already passed at %0d", it.tag, it.at, neg_cnt);
      end else begin
        check(it.tag, 32'({an, seg, dp}), 32'({it.an, it.seg, it.dp}));
      end
    end
  end

  task automatic step();
    @(posedge clk_c);
    e_now++;
    #2;
  endtask

  task automatic step_to(input int n);
    while (e_now < n) step();
  endtask

  // Expect reset-state outputs at the next falling edge.
  task automatic expect_next(input string tag);
    exp_t it;
    it.at  = neg_cnt + 1;
    it.an  = 4'b1111;
    it.seg = SOFF;
    it.dp  = 1'b1;
    it.tag = tag;
    sb.push_back(it);
  endtask

  // Push the first nj samples of frame k. s0..s3 are the slot 0..3 patterns;
  // hide[j] marks positions where the adjust blink blanks the digit.
  task automatic push_frame(input int k, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [15:0] hide, input int nj);
    logic [6:0] segs [4];
    logic [3:0] ans  [4];
    segs = '{s0, s1, s2, s3};
    ans  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int j = 0; j < nj; j++) begin
      exp_t it;
      int   s;
      s      = j / 4;
      it.at  = rel_base + 16 * k + 1 + j;
      it.tag = $sformatf("frame%0d_slot%0d_pos%0d", k, s, j % 4);
      if (j % 4 == 0) begin
        it.an  = 4'b1111;
        it.seg = SOFF;
        it.dp  = 1'b1;
      end else if (hide[j]) begin
        it.an  = ans[s];
        it.seg = SOFF;
        it.dp  = 1'b1;
      end else begin
        it.an  = ans[s];
        it.seg = segs[s];
        it.dp  = (s == 2) ? 1'b0 : 1'b1;
      end
      sb.push_back(it);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ADJ = 1'b0; SEL = 2'b00;
    min_tens = 4'd0; min_ones = 4'd0; sec_tens = 4'd0; sec_ones = 4'd0;
    #1 reset_c = 1'b1;
    step(); expect_next("reset_state_0");
    step(); expect_next("reset_state_1");
    step();

    // Release with digits 1,2,3,4 (min_tens..sec_ones).
    reset_c  = 1'b0;
    min_tens = 4'd1; min_ones = 4'd2; sec_tens = 4'd3; sec_ones = 4'd4;
    e_now    = 0;
    rel_base = neg_cnt + 1;
    push_frame(0, S4, S3, S2, S1, 16'h0000, 16);

    step_to(16); push_frame(1, S4, S3, S2, S1, 16'h0000, 16);
    step_to(18); sec_ones = 4'd5;          // mid-frame: slot 0 holds 4 until next frame
    step_to(32); push_frame(2, S5, S3, S2, S1, 16'h0000, 16);
    step_to(38); sec_tens = 4'hC;          // non-BCD, shows a dash from next frame
    // Change right before the snapshot edge: the value present on that edge is captured.
    step_to(48); min_ones = 4'd7;
    push_frame(3, S5, SDASH, S7, S1, 16'h0000, 16);

    // Adjust min_ones: synced at edge 66, hidden outputs on edges 75..82, 91..98.
    step_to(64); ADJ = 1'b1; SEL = 2'b10;
    push_frame(4, S5, SDASH, S7, S1, 16'h0C00, 16);
    step_to(80); push_frame(5, S5, SDASH, S7, S1, 16'h0C00, 16);
    step_to(96); ADJ = 1'b0;
    push_frame(6, S5, SDASH, S7, S1, 16'h0000, 16);
    step_to(100);
    check("blink_idle_after_adj_drop", 32'({dut.phase_q, dut.blink_cnt_q}), 32'd0);
    step_to(112); push_frame(7, S5, SDASH, S7, S1, 16'h0000, 16);
    step_to(128); push_frame(8, S5, SDASH, S7, S1, 16'h0000, 1);

    // Asynchronous reset mid-slot (slot 0 lit): outputs clear before the next edge.
    step_to(130);
    reset_c = 1'b1;
    expect_next("reset_async_same_cycle");
    step(); expect_next("reset_async_hold_0");
    step(); expect_next("reset_async_hold_1");

    // Release with a new sec_ones: the first lit slot shows the fresh snapshot.
    step();
    reset_c  = 1'b0;
    sec_ones = 4'd9;
    e_now    = 0;
    rel_base = neg_cnt + 1;
    push_frame(0, S9, SDASH, S7, S1, 16'h0000, 16);
    step_to(16);

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk_c);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
